uart_cmd_wrapper: RTL

UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

---
 rtl/uart_cmd_wrapper.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_cmd_wrapper.sv
// uart_cmd_wrapper: 8N1 UART that assembles two received bytes into a 16-bit command and transmits response bytes
// The RX and TX engines run independently; a byte strobe feeds the WAIT_HI/WAIT_LO command assembler.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV   = 2604,
  parameter int IB_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(IB_TIMEOUT * BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF   = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL   = CW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TO_LIM = TW'(IB_TIMEOUT * BAUD_DIV - 1);
  typedef enum logic {RX_IDLE, RX_BUSY} rx_st_t;
  typedef enum logic {WAIT_HI, WAIT_LO} cmd_st_t;
  typedef enum logic {TX_IDLE, TX_SHIFT} tx_st_t;
  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  rx_st_t        r_rx_st;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]    r_rx_bit;
  logic [7:0]    r_rx_byte;
  logic          r_byte_stb;
  cmd_st_t       r_st;
  logic [7:0]    r_hi;
  logic [TW-1:0] r_to_cnt;
  tx_st_t        r_tx_st;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic [8:0]    r_tx_shift;
  logic          w_rx_start, w_rx_tick;
  assign w_rx_start = (r_rx_st == RX_IDLE) && r_rx_prev && !r_rx_sync;
  assign w_rx_tick  = r_rx_cnt == ((r_rx_bit == 4'd0) ? HALF : FULL);
  // bit index 0 is the start bit (half-period sample), 1..8 data, 9 stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_byte  <= '0;
      r_byte_stb <= 1'b0;
    end else begin
      r_rx_meta  <= RX;
      r_rx_sync  <= r_rx_meta;
      r_rx_prev  <= r_rx_sync;
      r_byte_stb <= 1'b0;
      if (w_rx_start) begin
        r_rx_st  <= RX_BUSY;
        r_rx_cnt <= '0;
        r_rx_bit <= '0;
      end else if (r_rx_st == RX_BUSY) begin
        if (!w_rx_tick) r_rx_cnt <= r_rx_cnt + 1'b1;
        else begin
          r_rx_cnt <= '0;
          r_rx_bit <= r_rx_bit + 4'd1;
          if (r_rx_bit != 4'd0 && r_rx_bit != 4'd9) r_rx_byte <= {r_rx_sync, r_rx_byte[7:1]};
          if (r_rx_bit == 4'd9) begin
            r_rx_st    <= RX_IDLE;
            r_rx_bit   <= '0;
            r_byte_stb <= r_rx_sync;
          end
        end
      end
    end
  end
  // inter-byte timeout only advances while the receiver is idle in WAIT_LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st     <= WAIT_HI;
      r_hi     <= '0;
      r_to_cnt <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
    end else begin
      if (r_st == WAIT_HI) begin
        if (r_byte_stb) begin
          r_hi     <= r_rx_byte;
          r_st     <= WAIT_LO;
          r_to_cnt <= '0;
        end
      end else if (r_byte_stb) begin
        cmd  <= {r_hi, r_rx_byte};
        r_st <= WAIT_HI;
      end else if (r_rx_st == RX_IDLE && !w_rx_start) begin
        if (r_to_cnt == TO_LIM) r_st <= WAIT_HI;
        else r_to_cnt <= r_to_cnt + 1'b1;
      end
      cmd_rdy <= (r_st == WAIT_LO && r_byte_stb) ? 1'b1 :
                 (clr_cmd_rdy || (r_st == WAIT_HI && r_byte_stb)) ? 1'b0 : cmd_rdy;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TX         <= 1'b1;
      resp_sent  <= 1'b0;
      r_tx_st    <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else if (r_tx_st == TX_IDLE) begin
      if (send_resp) begin
        TX         <= 1'b0;
        resp_sent  <= 1'b0;
        r_tx_st    <= TX_SHIFT;
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
        r_tx_shift <= {1'b1, resp};
      end
    end else if (r_tx_cnt != FULL) r_tx_cnt <= r_tx_cnt + 1'b1;
    else begin
      r_tx_cnt <= '0;
      if (r_tx_bit == 4'd9) begin
        r_tx_st   <= TX_IDLE;
        r_tx_bit  <= '0;
        resp_sent <= 1'b1;
      end else begin
        r_tx_bit   <= r_tx_bit + 4'd1;
        TX         <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
      end
    end
  end
endmodule
